csa_stream_accumulator: RTL and testbench

Accumulates a stream of wide operands in carry-save (redundant sum/carry) form, one operand per cycle, and converts the result to binary with a multi-cycle chunked carry-propagate adder when the frame ends. It is the sequential, parametrised successor to the combinational per-bit 3:2 compressor array. It sits in the Montgomery/RSA datapath, where partial products arrive back-to-back and only the final sum needs a full-width carry resolution. Full-width carry chains are never built; resolution uses one Size_bi-bit adder iterated over the word.

---
 rtl/csa_stream_accumulator.sv | 121 ++++++++++++
 tb/tb_csa_stream_accumulator.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_stream_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : csa_stream_accumulator
//  Purpose  : Carry-save accumulation of a beat stream, followed by a chunked
//             carry-propagate resolution to a registered binary result.
//  Revision : 1.0  initial release
// ============================================================================
module csa_stream_accumulator #(
    parameter int Size     = 3072,
    parameter int Size_bi  = 64,
    parameter int Size_log = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [Size+Size_bi+Size_log-1:0]  in_data,
    input  logic                              in_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [Size+Size_bi+Size_log-1:0]  out_data
);

    localparam int c_W  = Size + Size_bi + Size_log;
    localparam int c_N  = (c_W + Size_bi - 1) / Size_bi;
    localparam int c_WP = c_N * Size_bi;
    localparam int c_KW = (c_N > 1) ? $clog2(c_N) : 1;

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_RES = 2'd1,
        ST_OUT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [c_W-1:0]    r_s;
    logic [c_W-1:0]    r_c;
    logic [c_WP-1:0]   r_res;
    logic [c_KW-1:0]   r_k;
    logic              r_cy;
    logic [c_W-1:0]    w_xor;
    logic [c_W-1:0]    w_maj;
    logic [Size_bi:0]  w_chunk;
    logic              w_beat;

    assign in_ready  = (r_state == ST_ACC) && !rst;
    assign out_valid = (r_state == ST_OUT);
    assign out_data  = r_res[c_W-1:0];
    assign w_beat    = in_valid && in_ready;

    // 3:2 compression of the redundant pair with the incoming operand
    assign w_xor = r_s ^ r_c ^ in_data;
    assign w_maj = (r_s & r_c) | (r_s & in_data) | (r_c & in_data);

    // S and C are shifted down during resolution, so the active chunk is
    // always the low Size_bi bits; zeros fill in above the top chunk.
    assign w_chunk = {1'b0, r_s[Size_bi-1:0]} + {1'b0, r_c[Size_bi-1:0]}
                   + {{Size_bi{1'b0}}, r_cy};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACC: if (w_beat && in_last)           w_state_next = ST_RES;
            ST_RES: if (r_k == c_KW'(c_N - 1))       w_state_next = ST_OUT;
            ST_OUT: if (out_ready)                   w_state_next = ST_ACC;
            default:                                 w_state_next = ST_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s   <= '0;
            r_c   <= '0;
            r_res <= '0;
            r_k   <= '0;
            r_cy  <= 1'b0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (w_beat) begin
                        r_s <= w_xor;
                        r_c <= w_maj << 1;
                        if (in_last) begin
                            r_k  <= '0;
                            r_cy <= 1'b0;
                        end
                    end
                end
                ST_RES: begin
                    // Result chunks enter at the top; after c_N steps chunk 0
                    // sits at bit 0 and any bits above c_W are dropped.
                    r_s   <= r_s >> Size_bi;
                    r_c   <= r_c >> Size_bi;
                    r_cy  <= w_chunk[Size_bi];
                    r_res <= {w_chunk[Size_bi-1:0], r_res[c_WP-1:Size_bi]};
                    r_k   <= r_k + 1'b1;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_s <= '0;
                        r_c <= '0;
                    end
                end
                default: begin
                    r_k <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csa_stream_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csa_stream_accumulator
//  Purpose  : Self-checking bench for both the small and default configs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_csa_stream_accumulator;

    localparam int WS = 12;
    localparam int NS = 3;
    localparam int WB = 3144;
    localparam int NB = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid;
    logic          in_last;
    logic          out_ready;
    logic          sel;
    logic [WB-1:0] in_data;

    logic          s_in_ready, s_out_valid, b_in_ready, b_out_valid;
    logic [WS-1:0] s_out_data;
    logic [WB-1:0] b_out_data;

    logic          in_ready_m, out_valid_m;
    logic [WB-1:0] out_data_m;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            frame_no = 0;
    int            cur_w, cur_n;
    logic [WB-1:0] mask;
    logic [WB-1:0] q[$];

    csa_stream_accumulator #(.Size(8), .Size_bi(4), .Size_log(0)) u_small (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid & ~sel),
        .in_ready  (s_in_ready),
        .in_data   (in_data[WS-1:0]),
        .in_last   (in_last),
        .out_valid (s_out_valid),
        .out_ready (out_ready & ~sel),
        .out_data  (s_out_data)
    );

    csa_stream_accumulator u_big (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid & sel),
        .in_ready  (b_in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (b_out_valid),
        .out_ready (out_ready & sel),
        .out_data  (b_out_data)
    );

    always_comb begin
        out_data_m = '0;
        if (sel) begin
            in_ready_m  = b_in_ready;
            out_valid_m = b_out_valid;
            out_data_m  = b_out_data;
        end else begin
            in_ready_m  = s_in_ready;
            out_valid_m = s_out_valid;
            out_data_m[WS-1:0] = s_out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic select(input bit b);
        sel   = b;
        cur_w = b ? WB : WS;
        cur_n = b ? NB : NS;
        mask  = b ? {WB{1'b1}} : ((WB'(1) << WS) - WB'(1));
    endtask

    function automatic logic [WB-1:0] rand_operand();
        logic [WB-1:0] v;
        if ($urandom_range(0, 7) == 0) return mask;
        v = '0;
        for (int i = 0; i < (WB + 31) / 32; i++) v = (v << 32) | WB'($urandom);
        return v & mask;
    endfunction

    // Drives q as one frame, waits for the result and checks it. The
    // expected sum is the plain modular sum of the beats unless use_exp.
    task automatic run_frame(input int max_gap, input int max_hold,
                             input logic [WB-1:0] exp_in, input bit use_exp,
                             input bit do_handshake, input string tag);
        logic [WB-1:0] model;
        logic [WB-1:0] expv;
        logic [127:0]  g_lo, e_lo;
        int            cnt;
        int            gaps;
        model = '0;
        frame_no++;
        foreach (q[i]) begin
            gaps = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            repeat (gaps) begin
                in_valid = 1'b0;
                in_data  = rand_operand();
                in_last  = $urandom_range(0, 1);
                tick();
            end
            in_valid = 1'b1;
            in_data  = q[i];
            in_last  = (i == q.size() - 1);
            n_checks++;
            if (in_ready_m !== 1'b1) begin
                n_fail++;
                $display("FAIL %s beat_ready frame %0d beat %0d: in_ready got %b expected 1",
                         tag, frame_no, i, in_ready_m);
            end
            model = (model + q[i]) & mask;
            tick();
        end
        // Garbage beats offered during resolution must be ignored.
        cnt = 1;
        while (out_valid_m !== 1'b1 && cnt < cur_n + 20) begin
            in_valid = (max_gap > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data  = rand_operand();
            in_last  = $urandom_range(0, 1);
            tick();
            cnt++;
        end
        n_checks++;
        if (cnt != cur_n + 1) begin
            n_fail++;
            $display("FAIL %s latency frame %0d: out_valid after %0d cycles expected %0d",
                     tag, frame_no, cnt, cur_n + 1);
        end
        expv = use_exp ? exp_in : model;
        n_checks++;
        if (out_data_m !== expv) begin
            n_fail++;
            g_lo = out_data_m[127:0];
            e_lo = expv[127:0];
            $display("FAIL %s sum frame %0d: out_data[127:0] got %h expected %h",
                     tag, frame_no, g_lo, e_lo);
        end
        if (do_handshake) begin
            out_ready = 1'b0;
            repeat ((max_hold > 0) ? $urandom_range(0, max_hold) : 0) tick();
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            in_valid  = 1'b0;
            n_checks++;
            if (in_ready_m !== 1'b1 || out_valid_m !== 1'b0) begin
                n_fail++;
                $display("FAIL %s after_handshake frame %0d: in_ready/out_valid got %b%b expected 10",
                         tag, frame_no, in_ready_m, out_valid_m);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        select(1'b0);
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_data = '0;
        tick();
        tick();
        n_checks++;
        if (s_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b%b expected 00", s_in_ready, b_in_ready);
        end
        n_checks++;
        if (s_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b%b expected 00", s_out_valid, b_out_valid);
        end
        n_checks++;
        if (s_out_data !== '0 || b_out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_out_data: small got %h expected 0", s_out_data);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (s_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_in_ready: got %b%b expected 11", s_in_ready, b_in_ready);
        end
    endtask

    task automatic test_small_vectors();
        select(1'b0);
        q = '{WB'(12'h0FF), WB'(12'h001), WB'(12'h800)};
        run_frame(0, 0, WB'(12'h900), 1'b1, 1'b1, "three_beat");
        q = '{WB'(12'hFFF), WB'(12'h002)};
        run_frame(0, 0, WB'(12'h001), 1'b1, 1'b1, "wrap");
        q = '{WB'(12'hABC)};
        run_frame(0, 0, WB'(12'hABC), 1'b1, 1'b1, "single");
    endtask

    task automatic test_wide_ripple();
        logic [WB-1:0] e;
        select(1'b1);
        e    = {WB{1'b1}};
        e[1] = 1'b0;
        q = '{mask, mask, mask};
        run_frame(0, 0, e, 1'b1, 1'b1, "wide_ones");
    endtask

    task automatic test_backpressure();
        logic [WB-1:0] held;
        select(1'b0);
        q = '{WB'(12'h123), WB'(12'h456)};
        run_frame(0, 0, WB'(12'h579), 1'b1, 1'b0, "bp_frame");
        held = out_data_m;
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data  = rand_operand();
            in_last  = $urandom_range(0, 1);
            tick();
            n_checks++;
            if (out_valid_m !== 1'b1 || in_ready_m !== 1'b0 || out_data_m[WS-1:0] !== 12'h579) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: valid %b ready %b data %h expected 1 0 579",
                         c, out_valid_m, in_ready_m, out_data_m[WS-1:0]);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (in_ready_m !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: in_ready got %b expected 1", in_ready_m);
        end
        q = '{WB'(12'h005)};
        run_frame(0, 0, WB'(12'h005), 1'b1, 1'b1, "bp_next");
    endtask

    task automatic test_reset_mid_res();
        select(1'b0);
        in_valid = 1'b1; in_data = WB'(12'hAAA); in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid_m !== 1'b0 || in_ready_m !== 1'b1 || out_data_m !== '0) begin
            n_fail++;
            $display("FAIL mid_res_reset: valid %b ready %b data %h expected 0 1 000",
                     out_valid_m, in_ready_m, out_data_m[WS-1:0]);
        end
        q = '{WB'(12'h003), WB'(12'h004)};
        run_frame(0, 0, WB'(12'h007), 1'b1, 1'b1, "post_reset");
    endtask

    task automatic test_random();
        for (int f = 0; f < 1000; f++) begin
            select(f >= 600);
            q.delete();
            repeat ($urandom_range(1, 20)) q.push_back(rand_operand());
            run_frame(3, 3, '0, 1'b0, 1'b1, "random");
        end
    endtask

    initial begin
        sel = 1'b0; rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b0; in_data = '0;
        test_reset();
        test_small_vectors();
        test_wide_ripple();
        test_backpressure();
        test_reset_mid_res();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
